// File: rtl/lsu_mem_master.sv
// ============================================================================
// lsu_mem_master : load/store initiator between execute and data memory.
//                  Optional LSU_TIMEOUT_EN adds an ADDR/DATA watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_mem_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_format,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_wmask,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [1:0]              fmt_q, fmt_d;
   logic                    uns_q, uns_d;
   logic [1:0]              off_q, off_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [3:0]              wmask_q, wmask_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;

   logic                    w_accept;
   logic                    w_misaligned;
   logic [3:0]              w_lane_mask;

`ifdef LSU_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [TMO_W-1:0] C_TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
   logic [TMO_W-1:0]        cnt_q, cnt_d;
`endif

   function automatic logic [DATA_WIDTH-1:0] extract_load(
      input logic [DATA_WIDTH-1:0] raw,
      input logic [1:0]            off,
      input logic [1:0]            fmt,
      input logic                  uns
   );
      logic [DATA_WIDTH-1:0] sh;
      sh = raw >> {off, 3'b000};
      case (fmt)
         2'b00:   extract_load = {{(DATA_WIDTH-8){~uns & sh[7]}}, sh[7:0]};
         2'b01:   extract_load = {{(DATA_WIDTH-16){~uns & sh[15]}}, sh[15:0]};
         default: extract_load = raw;
      endcase
   endfunction

   assign w_accept = req_valid & req_ready;

   always_comb begin
      w_misaligned = 1'b0;
      w_lane_mask  = 4'b1111;
      case (req_format)
         2'b00: w_lane_mask = 4'b0001 << req_addr[1:0];
         2'b01: begin
            w_lane_mask  = 4'b0011 << req_addr[1:0];
            w_misaligned = req_addr[0];
         end
         default: w_misaligned = |req_addr[1:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      fmt_d   = fmt_q;
      uns_d   = uns_q;
      off_d   = off_q;
      addr_d  = addr_q;
      wmask_d = wmask_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               we_d    = req_we;
               fmt_d   = req_format;
               uns_d   = req_unsigned;
               off_d   = req_addr[1:0];
               addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
               wmask_d = req_we ? w_lane_mask : 4'b0000;
               wdata_d = req_wdata << {req_addr[1:0], 3'b000};
               rdata_d = '0;
               err_d   = w_misaligned;
               state_d = w_misaligned ? S_RESP : S_ADDR;
`ifdef LSU_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_ADDR: begin
            if (mem_ready) state_d = S_DATA;
         end
         S_DATA: begin
            if (mem_resp_valid) begin
               rdata_d = we_q ? '0 : extract_load(mem_rdata, off_q, fmt_q, uns_q);
               state_d = S_RESP;
            end
         end
         default: begin
            if (resp_ready) state_d = S_IDLE;
         end
      endcase
`ifdef LSU_TIMEOUT_EN
      // A completion arriving on the expiry edge still wins over the watchdog.
      if (state_q == S_ADDR || state_q == S_DATA) begin
         cnt_d = cnt_q + TMO_W'(1);
         if (cnt_d == C_TMO_LIMIT && !(state_q == S_DATA && mem_resp_valid)) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         fmt_q   <= 2'b00;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         addr_q  <= '0;
         wmask_q <= 4'b0000;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         fmt_q   <= fmt_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         wmask_q <= wmask_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Reset is synchronous, so outputs are also masked while rst_n is low.
   assign req_ready  = rst_n & (state_q == S_IDLE);
   assign mem_valid  = rst_n & (state_q == S_ADDR);
   assign resp_valid = rst_n & (state_q == S_RESP);
   assign mem_we     = rst_n & we_q;
   assign mem_addr   = rst_n ? addr_q  : '0;
   assign mem_wmask  = rst_n ? wmask_q : 4'b0000;
   assign mem_wdata  = rst_n ? wdata_q : '0;
   assign resp_rdata = rst_n ? rdata_q : '0;
   assign resp_err   = rst_n & err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
// ============================================================================
// tb_lsu_mem_master : directed plus randomized checks of lsu_mem_master
//                     against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_format;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_valid, mem_ready, mem_we, mem_resp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   lsu_mem_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_format     (req_format),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wmask      (mem_wmask),
      .mem_wdata      (mem_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: access size in bytes, alignment, lanes and extension from plain arithmetic.
   task automatic model(input logic we, input logic [1:0] fmt, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        output logic mis, output logic [3:0] emask, output logic [31:0] ewdata,
                        output logic [31:0] erdata);
      int          n;
      int          off;
      logic [63:0] v;
      logic [63:0] keep;
      off  = int'(addr % 4);
      n    = (fmt == 2'd0) ? 1 : (fmt == 2'd1) ? 2 : 4;
      mis  = (off % n) != 0;
      emask  = we ? 4'(((1 << n) - 1) << off) : 4'b0000;
      ewdata = 32'({32'b0, wdata} << (8 * off));
      keep = (64'd1 << (8 * n)) - 64'd1;
      v    = ({32'b0, rdata} >> (8 * off)) & keep;
      if (!uns && n < 4 && v[8*n-1]) v = v | ~keep;
      erdata = (we || mis) ? 32'd0 : v[31:0];
   endtask

   task automatic do_txn(input logic we, input logic [1:0] fmt, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int mw, input int dw, input int rw);
      logic        mis;
      logic [3:0]  emask;
      logic [31:0] ewdata, erdata;
      int          t0;
      model(we, fmt, uns, addr, wdata, rdata, mis, emask, ewdata, erdata);
      step();
      check("idle_req_ready", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_format = fmt; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      t0 = cyc;
      step();
      req_valid = 1'b0;
      req_we = $urandom; req_format = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
      if (mis) begin
         check("mis_no_mem_valid", mem_valid, 0);
         check("mis_resp_next", resp_valid, 1);
      end else begin
         for (int i = 0; i <= mw; i++) begin
            check("addr_mem_valid", mem_valid, 1);
            check("addr_req_ready", req_ready, 0);
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("mem_we", mem_we, we);
            check("mem_wmask", mem_wmask, emask);
            if (we) check("mem_wdata", mem_wdata, ewdata);
            mem_ready      = (i == mw);
            mem_resp_valid = $urandom;
            mem_rdata      = $urandom;
            step();
         end
         mem_ready = 1'b0;
         for (int i = 0; i <= dw; i++) begin
            check("data_mem_valid", mem_valid, 0);
            check("data_resp_valid", resp_valid, 0);
            mem_resp_valid = (i == dw);
            mem_rdata      = (i == dw) ? rdata : $urandom;
            step();
         end
         mem_resp_valid = 1'b0;
         mem_rdata      = $urandom;
         if (mw == 0 && dw == 0) check("latency", 32'(cyc - t0), 3);
      end
      for (int i = 0; i <= rw; i++) begin
         check("resp_valid", resp_valid, 1);
         check("resp_rdata", resp_rdata, erdata);
         check("resp_err", resp_err, mis);
         check("resp_req_ready", req_ready, 0);
         resp_ready = (i == rw);
         step();
      end
      resp_ready = 1'b0;
      check("after_resp_valid", resp_valid, 0);
      check("after_req_ready", req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_format = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_rdata = '0;
      step(); step();
      req_valid = 1'b1;
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_valid", mem_valid, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      req_valid = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      check("post_rst_req_ready", req_ready, 1);

      // Directed vectors from the test plan.
      do_txn(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h8A12_3456, 0, 0, 0);
      do_txn(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 32'h8A12_3456, 0, 0, 0);
      do_txn(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h8A12_3456, 1, 2, 1);
      do_txn(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00AB, 32'h0, 0, 0, 0);
      do_txn(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 0, 1, 0);
      do_txn(1'b1, 2'd2, 1'b0, 32'h8000_0002, 32'h1234_5678, 32'h0, 0, 0, 0);
      do_txn(1'b0, 2'd1, 1'b0, 32'h8000_0001, 32'h0, 32'h1111_2222, 0, 0, 0);
      do_txn(1'b0, 2'd3, 1'b0, 32'h8000_0004, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
      do_txn(1'b0, 2'd2, 1'b1, 32'h8000_0008, 32'h0, 32'h8765_4321, 5, 0, 3);

      for (int k = 0; k < 200; k++) begin
         do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Reset while waiting in DATA abandons the load; a late completion is ignored.
      step();
      req_valid = 1'b1; req_we = 1'b0; req_format = 2'd2; req_addr = 32'h8000_0010;
      step();
      req_valid = 1'b0; mem_ready = 1'b1;
      check("rstdata_mem_valid", mem_valid, 1);
      step();
      mem_ready = 1'b0;
      check("rstdata_in_data", mem_valid, 0);
      rst_n = 1'b0;
      #1;
      check("rstlow_req_ready", req_ready, 0);
      check("rstlow_resp_valid", resp_valid, 0);
      step();
      rst_n = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      check("rstdone_req_ready", req_ready, 1);
      check("rstdone_mem_addr", mem_addr, 0);
      step();
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late_resp_valid", resp_valid, 0);
         check("late_mem_valid", mem_valid, 0);
         step();
      end

`ifdef LSU_TIMEOUT_EN
      req_valid = 1'b1; req_we = 1'b0; req_format = 2'd2; req_addr = 32'h8000_0020;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("tmo_mem_valid", mem_valid, 1);
         step();
      end
      mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
      check("tmo_resp_valid", resp_valid, 1);
      check("tmo_resp_err", resp_err, 1);
      check("tmo_resp_rdata", resp_rdata, 0);
      check("tmo_mem_dropped", mem_valid, 0);
      resp_ready = 1'b1;
      step();
      mem_resp_valid = 1'b0; resp_ready = 1'b0;
      check("tmo_done_resp_valid", resp_valid, 0);
      check("tmo_done_req_ready", req_ready, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
